// File: rtl/game_round_ctrl.sv
// Hoop game round controller: pre-start countdown, round timer, debounced per-hoop
// scoring and a one-cycle round_done strobe.
//   state    | meaning
//   IDLE     | waiting for start, time_left 0
//   PRESTART | get-ready countdown, hoops ignored
//   PLAY     | round timer running, hoops score
//   DONE     | scores and time frozen until the next start
module game_round_ctrl #(
  parameter int CLK_HZ        = 50000000,
  parameter int ROUND_SECS    = 30,
  parameter int PRESTART_SECS = 3,
  parameter int NUM_HOOPS     = 2,
  parameter int SCORE_W       = 8,
  parameter int DEBOUNCE_CYC  = 500000
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_HOOPS-1:0]          hoop_in,
  output logic [1:0]                    state,
  output logic [7:0]                    time_left,
  output logic [NUM_HOOPS*SCORE_W-1:0]  score,
  output logic [SCORE_W-1:0]            total_score,
  output logic                          round_done
);

  localparam int TW    = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int DW    = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int SUM_W = SCORE_W + 3;
  localparam logic [TW-1:0]      TICK_LAST = TW'(CLK_HZ - 1);
  localparam logic [DW-1:0]      DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;
  localparam logic [7:0]         ROUND_T   = 8'(ROUND_SECS);
  localparam logic [7:0]         PRE_T     = 8'(PRESTART_SECS);

  typedef enum logic [1:0] {IDLE = 2'd0, PRESTART = 2'd1, PLAY = 2'd2, DONE = 2'd3} state_t;

  logic [NUM_HOOPS-1:0]          sync1, sync2, level, hit;
  logic [NUM_HOOPS-1:0][DW-1:0]  db_cnt;

  state_t                                cur, nxt;
  logic [7:0]                            time_q, time_nx;
  logic [NUM_HOOPS-1:0][SCORE_W-1:0]     score_q, score_nx;
  logic                                  done_q, done_nx;
  logic [TW-1:0]                         tick_cnt, tick_nx;
  logic                                  tick;
  logic [SUM_W-1:0]                      sum;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= hoop_in;
      sync2 <= sync1;
    end
  end

  // Accepted level flips on the DEBOUNCE_CYC-th consecutive differing sample.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      level  <= '0;
      db_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_HOOPS; i++) begin
        if (sync2[i] != level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            level[i]  <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + DW'(1);
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_HOOPS; i++)
      hit[i] = sync2[i] & ~level[i] & (db_cnt[i] == DB_LAST);
  end

  assign tick = ((cur == PRESTART) || (cur == PLAY)) && (tick_cnt == TICK_LAST);

  always_comb begin
    nxt      = cur;
    time_nx  = time_q;
    score_nx = score_q;
    done_nx  = 1'b0;
    tick_nx  = '0;
    case (cur)
      IDLE, DONE: begin
        if (start) begin
          score_nx = '0;
          if (PRESTART_SECS == 0) begin
            nxt     = PLAY;
            time_nx = ROUND_T;
          end else begin
            nxt     = PRESTART;
            time_nx = PRE_T;
          end
        end
      end
      PRESTART: begin
        if (tick) begin
          if (time_q == 8'd1) begin
            nxt     = PLAY;
            time_nx = ROUND_T;
          end else begin
            time_nx = time_q - 8'd1;
          end
        end
      end
      PLAY: begin
        for (int i = 0; i < NUM_HOOPS; i++)
          if (hit[i] && (score_q[i] != SCORE_MAX))
            score_nx[i] = score_q[i] + SCORE_W'(1);
        if (tick) begin
          if (time_q == 8'd1) begin
            nxt     = DONE;
            time_nx = 8'd0;
            done_nx = 1'b1;
          end else begin
            time_nx = time_q - 8'd1;
          end
        end
      end
    endcase
    // Fresh full second on every phase entry.
    if ((nxt == cur) && !tick && ((cur == PRESTART) || (cur == PLAY)))
      tick_nx = tick_cnt + TW'(1);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cur      <= IDLE;
      time_q   <= '0;
      score_q  <= '0;
      done_q   <= 1'b0;
      tick_cnt <= '0;
    end else begin
      cur      <= nxt;
      time_q   <= time_nx;
      score_q  <= score_nx;
      done_q   <= done_nx;
      tick_cnt <= tick_nx;
    end
  end

  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_HOOPS; i++)
      sum = sum + SUM_W'(score_q[i]);
    total_score = (sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : sum[SCORE_W-1:0];
  end

  assign state      = cur;
  assign time_left  = time_q;
  assign score      = score_q;
  assign round_done = done_q;

endmodule
